pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It consumes the hazard and stall requests already produced in ID, plus the memory and mul/div handshakes. From these it drives per-stage register enables and bubble inserts for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It owns the multi-cycle mul/div handshake and keeps saturating stall/flush counters for performance debug.

---
 rtl/pipe_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage enables/bubbles for the 5-stage core,
// mul/div handshake tracking and saturating stall/flush debug counters.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_use_stall,
    input  logic             br_taken,
    input  logic             md_req,
    input  logic             md_done,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic dmem_stall;
    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c, md_start_c;

    assign dmem_stall = mem_req & ~dmem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (!dmem_stall && md_req) state_d = MD_BUSY;
            // md_done is a single pulse, so it is captured even while frozen
            MD_BUSY: if (md_done) state_d = MD_DONE;
            MD_DONE: if (!dmem_stall) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        md_start_c    = 1'b0;
        if (dmem_stall) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            memwb_en_c = 1'b0;
        end else if (state_q == MD_BUSY || (state_q == RUN && md_req)) begin
            // Hold the front end and the mul/div in EX; older work drains behind a bubble
            pc_en_c       = 1'b0;
            ifid_en_c     = 1'b0;
            idex_en_c     = 1'b0;
            exmem_flush_c = 1'b1;
            md_start_c    = (state_q == RUN);
        end else if (ld_use_stall) begin
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
        end else if (br_taken) begin
            ifid_flush_c = 1'b1;
        end else if (!imem_ready) begin
            pc_en_c      = 1'b0;
            ifid_flush_c = 1'b1;
        end
    end

    // Outputs are forced low for as long as reset is held, independent of the clock
    assign pc_en       = pc_en_c & rst_n;
    assign ifid_en     = ifid_en_c & rst_n;
    assign idex_en     = idex_en_c & rst_n;
    assign exmem_en    = exmem_en_c & rst_n;
    assign memwb_en    = memwb_en_c & rst_n;
    assign ifid_flush  = ifid_flush_c & rst_n;
    assign idex_flush  = idex_flush_c & rst_n;
    assign exmem_flush = exmem_flush_c & rst_n;
    assign md_start    = md_start_c & rst_n;
    assign md_busy     = (state_q == MD_BUSY) & rst_n;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!pc_en_c && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if ((ifid_flush_c || idex_flush_c || exmem_flush_c) && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_use_stall = 1'b0, br_taken = 1'b0, md_req = 1'b0, md_done = 1'b0;
    logic       imem_ready = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0, cnt_clr = 1'b0;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, md_start, md_busy;
    logic [3:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_use_stall(ld_use_stall), .br_taken(br_taken),
        .md_req(md_req), .md_done(md_done), .imem_ready(imem_ready),
        .mem_req(mem_req), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_start(md_start), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Input bit masks: {rst_n, ld, br, md_req, md_done, imem_ready, mem_req, dmem_ready, cnt_clr}
    localparam logic [8:0] R  = 9'h100, LD = 9'h080, BR = 9'h040, MQ = 9'h020, MD = 9'h010;
    localparam logic [8:0] IM = 9'h008, MR = 9'h004, DR = 9'h002, CL = 9'h001;
    // Enables {pc, ifid, idex, exmem, memwb}; flushes {ifid, idex, exmem}
    localparam logic [4:0] EA = 5'b11111, EN0 = 5'b00000;
    localparam logic [2:0] F0 = 3'b000, FIF = 3'b100, FID = 3'b010, FEX = 3'b001;

    typedef struct packed {
        logic [4:0] en;
        logic [2:0] fl;
        logic       st;
        logic       bz;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         vec_id = 0;
    logic [3:0] m_sc = 4'd0, m_fc = 4'd0;

    task automatic step(input logic [8:0] in, input logic [4:0] en, input logic [2:0] fl,
                        input logic st, input logic bz);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = in[8];
        ld_use_stall = in[7];
        br_taken     = in[6];
        md_req       = in[5];
        md_done      = in[4];
        imem_ready   = in[3];
        mem_req      = in[2];
        dmem_ready   = in[1];
        cnt_clr      = in[0];
        if (!in[8]) begin
            m_sc = 4'd0;
            m_fc = 4'd0;
        end
        e.en = en; e.fl = fl; e.st = st; e.bz = bz; e.sc = m_sc; e.fc = m_fc;
        exp_q.push_back(e);
        // Counter values seen in the next cycle
        if (in[8]) begin
            if (in[0]) begin
                m_sc = 4'd0;
                m_fc = 4'd0;
            end else begin
                if (!en[4] && m_sc != 4'hF) m_sc = m_sc + 4'd1;
                if ((|fl) && m_fc != 4'hF) m_fc = m_fc + 4'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic [4:0] a_en;
            logic [2:0] a_fl;
            e    = exp_q.pop_front();
            a_en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
            a_fl = {ifid_flush, idex_flush, exmem_flush};
            checks = checks + 4;
            if (a_en !== e.en) begin
                failures++;
                $display("FAIL v%0d enables: got %b want %b", vec_id, a_en, e.en);
            end
            if (a_fl !== e.fl) begin
                failures++;
                $display("FAIL v%0d flushes: got %b want %b", vec_id, a_fl, e.fl);
            end
            if ({md_start, md_busy} !== {e.st, e.bz}) begin
                failures++;
                $display("FAIL v%0d md_start/busy: got %b%b want %b%b", vec_id, md_start, md_busy, e.st, e.bz);
            end
            if ({stall_cnt, flush_cnt} !== {e.sc, e.fc}) begin
                failures++;
                $display("FAIL v%0d counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         vec_id, stall_cnt, flush_cnt, e.sc, e.fc);
            end
            $display("v%0d en=%b fl=%b st=%b bz=%b stall=%0d flush=%0d", vec_id, a_en, a_fl,
                     md_start, md_busy, stall_cnt, flush_cnt);
            vec_id++;
        end
    end

    initial begin
        // Reset state, then idle
        step(9'h000, EN0, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        // Load-use wins over a same-cycle taken branch
        step(R|LD|BR|IM, 5'b00111, FID, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        step(R|IM|CL, EA, F0, 0, 0);
        // Mul/div with md_done 4 cycles after md_start
        step(R|IM|MQ, 5'b00011, FEX, 1, 0);
        step(R|IM|MQ, 5'b00011, FEX, 0, 1);
        step(R|IM|MQ, 5'b00011, FEX, 0, 1);
        step(R|IM|MQ, 5'b00011, FEX, 0, 1);
        step(R|IM|MQ|MD, 5'b00011, FEX, 0, 1);
        step(R|IM|MQ, EA, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        // md_done inside a 3-cycle dmem stall
        step(R|IM|MQ, 5'b00011, FEX, 1, 0);
        step(R|IM|MQ|MR, EN0, F0, 0, 1);
        step(R|IM|MQ|MR|MD, EN0, F0, 0, 1);
        step(R|IM|MQ|MR, EN0, F0, 0, 0);
        step(R|IM|MQ|MR|DR, EA, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        // Taken branch over a pending fetch, then fetch still pending
        step(R|BR, EA, FIF, 0, 0);
        step(R, 5'b01111, FIF, 0, 0);
        // Counter saturation
        for (int i = 0; i < 20; i++) step(R, 5'b01111, FIF, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        step(R|CL, 5'b01111, FIF, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        // Reset mid MD_BUSY: no replay afterwards, stray md_done ignored
        step(R|IM|MQ, 5'b00011, FEX, 1, 0);
        step(R|IM|MQ, 5'b00011, FEX, 0, 1);
        step(MQ|IM, EN0, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);
        step(R|IM|MD, EA, F0, 0, 0);
        step(R|IM, EA, F0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
